spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 8: address and data width in bits.
REQ-002 Parameter TURN, default 2: SS_n-low idle cycles between end of read-data command bits and first MISO capture.
REQ-003 Parameter GAP, default 2: SS_n-high cycles between the two frames of one operation.
REQ-004 clk  input  1: single clock; all logic on rising edge.
REQ-005 rst_n  input  1: synchronous, active-low reset.
REQ-006 req_valid  input  1: operation request.
REQ-007 req_ready  output  1: controller can accept a request.
REQ-008 req_wr  input  1: 1 = write operation, 0 = read operation.
REQ-009 req_addr  input  ADDR_SIZE: RAM address.
REQ-010 req_wdata  input  ADDR_SIZE: write data; ignored for reads.
REQ-011 rsp_valid  output  1: one-cycle pulse, read data valid.
REQ-012 rsp_rdata  output  ADDR_SIZE: read data; held until next rsp_valid.
REQ-013 busy  output  1: operation in progress.
REQ-014 SS_n  output  1: slave select to SPI_Wrapper, active low.
REQ-015 MOSI  output  1: serial data to slave.
REQ-016 MISO  input  1: serial data from slave.

Function
REQ-017 Handshake: request accepted on a rising edge with req_valid=1 and req_ready=1; req_addr, req_wdata and req_wr are captured at that edge.
REQ-018 req_ready=1 only in IDLE; busy = ~req_ready.
REQ-019 States: IDLE, LEAD, SHIFT, TURN_WAIT, CAPTURE, GAP_WAIT.
REQ-020 Write operation: frame A = cmd 2'b00 with payload addr; GAP; frame B = cmd 2'b01 with payload wdata.
REQ-021 Read operation: frame A = cmd 2'b10 with payload addr; GAP; frame B = cmd 2'b11 with payload 0, then TURN_WAIT and CAPTURE.
REQ-022 Frame sequencing:
- LEAD: 1 cycle, SS_n=0, MOSI=0.
- SHIFT: 11 cycles, MOSI = select bit, cmd[1], cmd[0], payload MSB first.
- Select bit = cmd[1].
REQ-023 SS_n and MOSI are registered outputs; each bit is stable for exactly one clock.
REQ-024 After SHIFT of any frame other than the read-data frame: SS_n=1 and enter GAP_WAIT (after frame A) or IDLE (after frame B).
REQ-025 Read-data frame: after SHIFT, hold SS_n=0 and MOSI=0 for TURN cycles.
REQ-026 CAPTURE: ADDR_SIZE cycles; MISO sampled each rising edge and shifted in MSB first.
REQ-027 Last capture edge: rsp_rdata is updated and rsp_valid pulses for 1 cycle; SS_n=1 and the controller returns to IDLE.
REQ-028 GAP_WAIT: SS_n=1 and MOSI=0 for GAP cycles.
REQ-029 Latency from acceptance to return to IDLE:
- Write: 2*12 + GAP cycles.
- Read: 2*12 + GAP + TURN + ADDR_SIZE cycles.
REQ-030 Back-to-back requests: req_ready rises in the cycle after return to IDLE, so at least 1 SS_n-high cycle separates operations.
REQ-031 req_valid changes while busy are ignored; no queuing.
REQ-032 Bit counter is sized for max(11, TURN, GAP, ADDR_SIZE) and wraps to 0 at every state change.

Reset
REQ-033 rst_n=0 at a rising edge forces: IDLE, SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, counters=0.
REQ-034 Reset mid-frame aborts immediately: SS_n=1 on the next edge, no rsp_valid is issued, and the aborted request is dropped.
REQ-035 Reset has priority over a simultaneous req_valid.

Verification
REQ-036 Bench connects to SPI_Wrapper (MEM_DEPTH=256), with clk and rst_n common to both.
REQ-037 Write addr=8'hFF, wdata=8'hA5 -> RAM[255]=8'hA5; SS_n low for exactly 12+12 cycles, split by a 2-cycle gap.
REQ-038 Write addr=8'h10, wdata=8'h3C, then read addr=8'h10 -> exactly one rsp_valid pulse with rsp_rdata=8'h3C.
REQ-039 MOSI bit check for write addr=8'h81, wdata=8'h00 -> frame A MOSI sequence 0,0,0,1,0,0,0,0,0,0,1 and frame B sequence 0,0,1 followed by 8 zeros.
REQ-040 req_valid held high across two write operations -> req_ready=0 throughout each operation; second acceptance occurs at least 1 cycle after the first op's last SS_n-low cycle; both RAM locations are correct.
REQ-041 rst_n=0 during CAPTURE of a read -> next edge: SS_n=1, no rsp_valid, req_ready=1; a subsequent read of the same address returns the correct data.
REQ-042 req_valid=1 together with rst_n=0 -> request not accepted; SS_n stays 1.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master that runs two-frame RAM write/read operations against an SPI_Wrapper slave.
// Frame: one lead cycle, then select bit, 2-bit command and payload, MSB first.
module spi_master_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int TURN      = 2,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int SHIFT_LEN = ADDR_SIZE + 3;
  localparam int MAX_A     = (SHIFT_LEN > ADDR_SIZE) ? SHIFT_LEN : ADDR_SIZE;
  localparam int MAX_B     = (TURN > GAP) ? TURN : GAP;
  localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEAD      = 3'd1;
  localparam logic [2:0] S_SHIFT     = 3'd2;
  localparam logic [2:0] S_TURN_WAIT = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;
  localparam logic [2:0] S_GAP_WAIT  = 3'd5;

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 op_wr;
  logic                 frame_b;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [ADDR_SIZE-1:0] cap;
  logic [SHIFT_LEN-1:0] shreg;

  // cmd = {~wr, second}; the select bit repeats cmd[1] ahead of the command.
  function automatic logic [SHIFT_LEN-1:0] frame_word(input logic wr, input logic second,
                                                      input logic [ADDR_SIZE-1:0] payload);
    return {~wr, ~wr, second, payload};
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

  // NOTE: reset is sampled synchronously and all state uses non-blocking assignments,
  // so every register (including SS_n/MOSI) changes only on the rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      frame_b   <= 1'b0;
      wdata_q   <= '0;
      cap       <= '0;
      shreg     <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_wr   <= req_wr;
            wdata_q <= req_wdata;
            frame_b <= 1'b0;
            shreg   <= frame_word(req_wr, 1'b0, req_addr);
            SS_n    <= 1'b0;
            MOSI    <= 1'b0;
            cnt     <= '0;
            state   <= S_LEAD;
          end
        end
        S_LEAD: begin
          MOSI  <= shreg[SHIFT_LEN-1];
          shreg <= {shreg[SHIFT_LEN-2:0], 1'b0};
          cnt   <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (frame_b && !op_wr) begin
              // read-data frame keeps the slave selected through turnaround and capture
              state <= (TURN > 0) ? S_TURN_WAIT : S_CAPTURE;
            end else begin
              SS_n  <= 1'b1;
              state <= frame_b ? S_IDLE : S_GAP_WAIT;
            end
          end else begin
            MOSI  <= shreg[SHIFT_LEN-1];
            shreg <= {shreg[SHIFT_LEN-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
          end
        end
        S_GAP_WAIT: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            cnt     <= '0;
            frame_b <= 1'b1;
            shreg   <= frame_word(op_wr, 1'b1, op_wr ? wdata_q : '0);
            SS_n    <= 1'b0;
            state   <= S_LEAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_TURN_WAIT: begin
          if (cnt == CNT_W'(TURN - 1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          cap <= {cap[ADDR_SIZE-2:0], MISO};
          if (cnt == CNT_W'(ADDR_SIZE - 1)) begin
            rsp_rdata <= {cap[ADDR_SIZE-2:0], MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI_Wrapper slave (256-byte RAM) plus a
// spec-level model of frames, latencies and RAM contents, checked with assertions.
module tb_spi_master_ctrl;

  localparam int N         = 8;
  localparam int TURN      = 2;
  localparam int GAP       = 2;
  localparam int FRAME_LOW = N + 4;
  localparam int WR_LAT    = 2 * FRAME_LOW + GAP;
  localparam int RD_LAT    = 2 * FRAME_LOW + GAP + TURN + N;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         rsp_valid;
  logic [N-1:0] rsp_rdata;
  logic         busy;
  logic         SS_n;
  logic         MOSI;
  logic         MISO;

  spi_master_ctrl #(.ADDR_SIZE(N), .TURN(TURN), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave (SPI_Wrapper stand-in) ----------------
  logic [N-1:0] ram [256];
  logic [11:0]  s_sr;
  int           s_cnt = 0;
  logic [N-1:0] s_waddr, s_raddr, s_rdata;

  initial MISO = 1'b0;

  always @(negedge clk) begin
    if (SS_n !== 1'b0) begin
      s_cnt = 0;
      MISO  = 1'b0;
    end else begin
      s_cnt++;
      if (s_cnt <= FRAME_LOW) s_sr = {s_sr[10:0], MOSI};
      if (s_cnt == FRAME_LOW) begin
        case (s_sr[9:8])
          2'b00: s_waddr = s_sr[7:0];
          2'b01: ram[s_waddr] = s_sr[7:0];
          2'b10: s_raddr = s_sr[7:0];
          default: s_rdata = ram[s_raddr];
        endcase
      end
      if (s_cnt >= FRAME_LOW + TURN + 1 && s_cnt <= FRAME_LOW + TURN + N)
        MISO = s_rdata[FRAME_LOW + TURN + N - s_cnt];
      else
        MISO = 1'b0;
    end
  end

  // ---------------- observation trackers (updated once per cycle) ----------------
  logic [N-1:0] ref_mem [256];
  int           cyc = 0, low_len = 0, high_len = 0, busy_len = 0, last_low_cyc = 0;
  int           mosi_bad = 0, busy_bad = 0;
  logic [11:0]  frame_sr = '0;
  logic [11:0]  fr_a, fr_b;
  int           lows_q[$], highs_q[$], busy_q[$];
  logic [11:0]  frames_q[$];
  logic [N-1:0] rsp_q[$];

  task automatic step();
    @(negedge clk);
    cyc++;
    if (SS_n === 1'b0) begin
      if (high_len > 0) highs_q.push_back(high_len);
      high_len     = 0;
      low_len++;
      last_low_cyc = cyc;
      if (low_len <= FRAME_LOW) frame_sr = {frame_sr[10:0], MOSI};
      else if (low_len <= FRAME_LOW + TURN && MOSI !== 1'b0) mosi_bad++;
    end else begin
      if (low_len > 0) begin
        lows_q.push_back(low_len);
        frames_q.push_back(frame_sr);
      end
      low_len = 0;
      high_len++;
      if (MOSI !== 1'b0) mosi_bad++;
    end
    if (req_ready === 1'b0) busy_len++;
    else if (busy_len > 0) begin
      busy_q.push_back(busy_len);
      busy_len = 0;
    end
    if (busy !== ~req_ready) busy_bad++;
    if (rsp_valid === 1'b1) rsp_q.push_back(rsp_rdata);
  endtask

  task automatic clear_trk();
    lows_q.delete(); highs_q.delete(); busy_q.delete(); frames_q.delete(); rsp_q.delete();
    high_len = 0;
    busy_len = 0;
    low_len  = 0;
  endtask

  function automatic logic [11:0] exp_frame(input logic [1:0] cmd, input logic [N-1:0] pl);
    return {1'b0, cmd[1], cmd, pl};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, req_ready, 1);
  endtask

  // One full operation, with req_valid/req_wr jitter while busy that must be ignored.
  task automatic do_op(input logic wr, input logic [N-1:0] addr, input logic [N-1:0] wdata);
    int n;
    logic [N-1:0] pl_b;
    wait_ready("ready_before_op");
    clear_trk();
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_addr = N'($urandom); req_wdata = N'($urandom); req_wr = 1'($urandom);
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
      req_valid = (req_ready === 1'b0) ? 1'($urandom) : 1'b0;
    end
    req_valid = 1'b0;
    check("op_done", req_ready, 1);
    check("busy_runs", busy_q.size(), 1);
    if (busy_q.size() > 0) check("latency", busy_q[0], wr ? WR_LAT : RD_LAT);
    check("frame_count", frames_q.size(), 2);
    pl_b = wr ? wdata : '0;
    fr_a = '1;
    fr_b = '1;
    if (frames_q.size() >= 2) begin
      fr_a = frames_q[0];
      fr_b = frames_q[1];
    end
    check("frame_a_bits", fr_a, exp_frame({~wr, 1'b0}, addr));
    check("frame_b_bits", fr_b, exp_frame({~wr, 1'b1}, pl_b));
    if (lows_q.size() >= 2) begin
      check("ss_low_a", lows_q[0], FRAME_LOW);
      check("ss_low_b", lows_q[1], wr ? FRAME_LOW : FRAME_LOW + TURN + N);
    end else check("ss_low_count", lows_q.size(), 2);
    check("gap_len", (highs_q.size() > 0) ? highs_q[0] : -1, GAP);
    if (wr) begin
      check("wr_no_rsp", rsp_q.size(), 0);
      check("ram_written", ram[addr], wdata);
      ref_mem[addr] = wdata;
    end else begin
      check("rd_one_rsp", rsp_q.size(), 1);
      check("rd_rsp_data", (rsp_q.size() > 0) ? rsp_q[0] : 'x, ref_mem[addr]);
      step();
      check("rd_data_held", rsp_rdata, ref_mem[addr]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acc2_gap;
    logic [N-1:0] a;
    logic [N-1:0] wr_addrs[$];
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset state, with a request asserted during reset.
    rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h55; req_wdata = 8'h66;
    repeat (3) step();
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    clear_trk();
    repeat (4) step();
    check("rst_req_dropped", lows_q.size() + low_len, 0);
    check("idle_ss_n", SS_n, 1);

    // Write to the top address.
    do_op(1'b1, 8'hFF, 8'hA5);
    check("ram_255", ram[255], 8'hA5);

    // Write then read back.
    do_op(1'b1, 8'h10, 8'h3C);
    do_op(1'b0, 8'h10, 8'h00);
    check("readback_3c", rsp_rdata, 8'h3C);

    // MOSI bit pattern for addr 0x81, data 0x00.
    do_op(1'b1, 8'h81, 8'h00);
    check("mosi_seq_a", fr_a[10:0], 11'b000_1000_0001);
    check("mosi_seq_b", fr_b[10:0], 11'b001_0000_0000);

    // req_valid held high across two writes.
    wait_ready("ready_before_b2b");
    clear_trk();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h20; req_wdata = 8'h11;
    step();
    req_addr = 8'h21; req_wdata = 8'h22;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    acc2_gap = cyc - last_low_cyc;
    step();
    req_valid = 1'b0;
    wait_ready("b2b_done");
    check("b2b_busy_runs", busy_q.size(), 2);
    if (busy_q.size() >= 2) begin
      check("b2b_lat_1", busy_q[0], WR_LAT);
      check("b2b_lat_2", busy_q[1], WR_LAT);
    end
    check("b2b_gap_ge1", acc2_gap >= 1, 1);
    check("b2b_ram_1", ram[8'h20], 8'h11);
    check("b2b_ram_2", ram[8'h21], 8'h22);
    ref_mem[8'h20] = 8'h11;
    ref_mem[8'h21] = 8'h22;

    // Randomized operations against the reference memory.
    for (int i = 0; i < 12; i++) begin
      logic wr;
      wr = 1'($urandom);
      a  = N'($urandom);
      if (!wr && wr_addrs.size() > 0 && (i % 2 == 1))
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
      if (wr) wr_addrs.push_back(a);
      do_op(wr, a, N'($urandom));
    end

    // Reset priority over a simultaneous request while idle.
    wait_ready("ready_before_rst_prio");
    clear_trk();
    rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10;
    step();
    check("rst_prio_ss_n", SS_n, 1);
    check("rst_prio_ready", req_ready, 1);
    rst_n = 1'b1; req_valid = 1'b0;
    repeat (3) step();
    check("rst_prio_no_frame", lows_q.size() + low_len, 0);

    // Reset in the middle of CAPTURE.
    a = 8'h10;
    wait_ready("ready_before_abort");
    clear_trk();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    repeat (2 * FRAME_LOW + GAP + TURN + 3) step();
    check("abort_mid_frame", SS_n, 0);
    rst_n = 1'b0;
    step();
    check("abort_ss_n", SS_n, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 1);
    rst_n = 1'b1;
    repeat (2) step();
    check("abort_no_rsp", rsp_q.size(), 0);
    do_op(1'b0, a, 8'h00);
    check("abort_reread", rsp_rdata, ref_mem[a]);

    check("mosi_zero_when_idle", mosi_bad, 0);
    check("busy_is_not_ready", busy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
